// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks: flatten ordering codes,
// flatten-stage state encoding and a width helper.
package cnn_pkg;

    localparam int ORDER_CHW = 0;
    localparam int ORDER_HWC = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } flatten_state_t;

    // Counter width for a range of 'value' entries, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/flatten_index_gen.sv
// Nested channel/row/column counters walking a feature map in CHW or HWC order;
// produces the buffer offset of the current element plus its sequence index and last flag.
module flatten_index_gen
    import cnn_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int CHANNELS = 1,
    parameter int ORDER    = ORDER_CHW,
    localparam int N       = CHANNELS * ROWS * COLS,
    localparam int IDX_W   = clog2_min1(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    output logic [IDX_W-1:0] offset,
    output logic [IDX_W-1:0] index,
    output logic             last
);

    localparam int CW = clog2_min1(CHANNELS);
    localparam int RW = clog2_min1(ROWS);
    localparam int KW = clog2_min1(COLS);
    localparam logic [CW-1:0]    C_MAX = CW'(CHANNELS - 1);
    localparam logic [RW-1:0]    R_MAX = RW'(ROWS - 1);
    localparam logic [KW-1:0]    K_MAX = KW'(COLS - 1);
    localparam logic [IDX_W-1:0] S_MAX = IDX_W'(N - 1);

    logic [CW-1:0]    ch_q;
    logic [RW-1:0]    row_q;
    logic [KW-1:0]    col_q;
    logic [IDX_W-1:0] seq_q;
    logic             ch_wrap, row_wrap, col_wrap;

    assign ch_wrap  = (ch_q == C_MAX);
    assign row_wrap = (row_q == R_MAX);
    assign col_wrap = (col_q == K_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_q  <= '0;
            row_q <= '0;
            col_q <= '0;
            seq_q <= '0;
        end else if (clear) begin
            ch_q  <= '0;
            row_q <= '0;
            col_q <= '0;
            seq_q <= '0;
        end else if (advance) begin
            seq_q <= last ? '0 : seq_q + 1'b1;
            // Carry chain order is the only difference between the two layouts.
            if (ORDER == ORDER_HWC) begin
                ch_q <= ch_wrap ? '0 : ch_q + 1'b1;
                if (ch_wrap) begin
                    col_q <= col_wrap ? '0 : col_q + 1'b1;
                    if (col_wrap)
                        row_q <= row_wrap ? '0 : row_q + 1'b1;
                end
            end else begin
                col_q <= col_wrap ? '0 : col_q + 1'b1;
                if (col_wrap) begin
                    row_q <= row_wrap ? '0 : row_q + 1'b1;
                    if (row_wrap)
                        ch_q <= ch_wrap ? '0 : ch_q + 1'b1;
                end
            end
        end
    end

    assign offset = IDX_W'((int'(ch_q) * ROWS + int'(row_q)) * COLS + int'(col_q));
    assign index  = seq_q;
    assign last   = (seq_q == S_MAX);

endmodule

// File: rtl/flatten_stream.sv
// Captures a CHANNELS x ROWS x COLS feature map from a flat bus and streams it out
// one signed element per valid/ready transfer, with last/index sideband.
//   state     | meaning
//   ST_IDLE   | waiting for start; capture bus on start
//   ST_STREAM | presenting buffered elements, advancing on each transfer
//   ST_DONE   | one-cycle done pulse, busy still high
module flatten_stream
    import cnn_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int CHANNELS = 1,
    parameter int ORDER    = ORDER_CHW,
    localparam int N       = CHANNELS * ROWS * COLS,
    localparam int IDX_W   = clog2_min1(N)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [N*DATA_W-1:0]      feature_map_flat,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [IDX_W-1:0]         out_index,
    output logic                     busy,
    output logic                     done
);

    flatten_state_t      state_q, state_d;
    logic [N*DATA_W-1:0] fmap_q;
    logic [IDX_W-1:0]    offset, seq_idx;
    logic                seq_last;
    logic                capture, xfer;

    assign capture = (state_q == ST_IDLE) && start;
    assign xfer    = (state_q == ST_STREAM) && out_ready;

    flatten_index_gen #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .CHANNELS (CHANNELS),
        .ORDER    (ORDER)
    ) u_index_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (capture),
        .advance (xfer),
        .offset  (offset),
        .index   (seq_idx),
        .last    (seq_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Buffer content is irrelevant until the first capture, so it carries no reset.
    always_ff @(posedge clk) begin
        if (capture)
            fmap_q <= feature_map_flat;
    end

    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start)
                    state_d = ST_STREAM;
            end
            ST_STREAM: begin
                out_valid = 1'b1;
                if (out_ready && seq_last)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sideband is forced to zero outside STREAM so reset and idle read as all-zero.
    assign out_data  = out_valid ? fmap_q[int'(offset)*DATA_W +: DATA_W] : '0;
    assign out_index = out_valid ? seq_idx : '0;
    assign out_last  = out_valid && seq_last;

endmodule

// File: tb/tb_flatten_stream.sv
// Scoreboard bench for flatten_stream: four configurations share one clock and
// out_ready; expectations come from an arithmetic model of the element ordering.
module tb_flatten_stream;
    import cnn_pkg::*;

    localparam int ND = 4;
    localparam int P_CH  [ND] = '{1, 2, 2, 1};
    localparam int P_R   [ND] = '{4, 2, 2, 1};
    localparam int P_C   [ND] = '{4, 2, 2, 1};
    localparam int P_ORD [ND] = '{ORDER_CHW, ORDER_HWC, ORDER_CHW, ORDER_CHW};

    typedef struct {
        logic [15:0] data;
        int          idx;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ready = 1'b0;
    logic [ND-1:0] start;
    logic [255:0]  bus [ND];

    logic [ND-1:0][15:0] o_data;
    logic [ND-1:0]       o_valid, o_last, o_busy, o_done;
    logic [3:0]          idx0;
    logic [2:0]          idx1, idx2;
    logic [0:0]          idx3;

    exp_t exp_q [ND][$];
    int   n_pass = 0, n_total = 0;
    int   cyc = 0, rp = 0, ready_mode = 0;
    int   xfer_cnt [ND], done_cnt [ND], done_cyc [ND];
    bit   held_v [ND], prev_done [ND];
    longint held_val [ND];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    flatten_stream #(.DATA_W(16), .ROWS(4), .COLS(4), .CHANNELS(1), .ORDER(ORDER_CHW)) u_dflt (
        .clk(clk), .reset(reset), .start(start[0]), .feature_map_flat(bus[0][255:0]),
        .out_data(o_data[0]), .out_valid(o_valid[0]), .out_ready(ready), .out_last(o_last[0]),
        .out_index(idx0), .busy(o_busy[0]), .done(o_done[0]));

    flatten_stream #(.DATA_W(16), .ROWS(2), .COLS(2), .CHANNELS(2), .ORDER(ORDER_HWC)) u_hwc (
        .clk(clk), .reset(reset), .start(start[1]), .feature_map_flat(bus[1][127:0]),
        .out_data(o_data[1]), .out_valid(o_valid[1]), .out_ready(ready), .out_last(o_last[1]),
        .out_index(idx1), .busy(o_busy[1]), .done(o_done[1]));

    flatten_stream #(.DATA_W(16), .ROWS(2), .COLS(2), .CHANNELS(2), .ORDER(ORDER_CHW)) u_chw (
        .clk(clk), .reset(reset), .start(start[2]), .feature_map_flat(bus[2][127:0]),
        .out_data(o_data[2]), .out_valid(o_valid[2]), .out_ready(ready), .out_last(o_last[2]),
        .out_index(idx2), .busy(o_busy[2]), .done(o_done[2]));

    flatten_stream #(.DATA_W(16), .ROWS(1), .COLS(1), .CHANNELS(1), .ORDER(ORDER_CHW)) u_n1 (
        .clk(clk), .reset(reset), .start(start[3]), .feature_map_flat(bus[3][15:0]),
        .out_data(o_data[3]), .out_valid(o_valid[3]), .out_ready(ready), .out_last(o_last[3]),
        .out_index(idx3), .busy(o_busy[3]), .done(o_done[3]));

    function automatic int get_idx(input int d);
        case (d)
            0:       return int'(idx0);
            1:       return int'(idx1);
            2:       return int'(idx2);
            default: return int'(idx3);
        endcase
    endfunction

    // Reference ordering: sequence number -> flat bus element position.
    function automatic int src_pos(input int d, input int s);
        int c, r, k;
        int rr = P_R[d];
        int cc = P_C[d];
        int ch = P_CH[d];
        if (P_ORD[d] == ORDER_HWC) begin
            c = s % ch;
            k = (s / ch) % cc;
            r = s / (ch * cc);
        end else begin
            c = s / (rr * cc);
            r = (s / cc) % rr;
            k = s % cc;
        end
        return (c * rr + r) * cc + k;
    endfunction

    task automatic chk(input string name, input int d, input longint act, input longint exp);
        n_total++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", name, d, act, exp, $time);
    endtask

    function automatic longint pack_out(input int d);
        return (longint'(o_data[d]) << 9) | (longint'(get_idx(d)) << 1) | longint'(o_last[d]);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rp++;
            case (ready_mode)
                0:       ready = 1'b1;
                1:       ready = (rp % 4 == 0) || (rp % 4 == 3);
                default: ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < ND; d++) begin
                if (o_valid[d]) begin
                    if (held_v[d]) begin
                        chk("stall_hold", d, pack_out(d), held_val[d]);
                        held_v[d] = 1'b0;
                    end
                    if (ready) begin
                        if (exp_q[d].size() == 0) begin
                            chk("unexpected_xfer_index", d, get_idx(d), -1);
                        end else begin
                            exp_t e;
                            e = exp_q[d].pop_front();
                            chk("data", d, longint'($signed(o_data[d])), longint'($signed(e.data)));
                            chk("index", d, get_idx(d), e.idx);
                            chk("last", d, o_last[d], e.last);
                        end
                        xfer_cnt[d]++;
                    end else begin
                        held_v[d]   = 1'b1;
                        held_val[d] = pack_out(d);
                    end
                end
                if (o_done[d]) begin
                    done_cnt[d]++;
                    done_cyc[d] = cyc;
                    chk("done_valid_low", d, o_valid[d], 0);
                    chk("done_busy_high", d, o_busy[d], 1);
                end
                if (prev_done[d])
                    chk("busy_low_after_done", d, o_busy[d], 0);
                prev_done[d] = o_done[d];
            end
        end
    end

    // fill: 0 = element value equals its bus position, 1 = +1..+4 / -1..-4 channels, 2 = random.
    task automatic run_stream(input int d, input int fill, input int mode, input bit mid, input int rst_at);
        int n = P_CH[d] * P_R[d] * P_C[d];
        int base_done = done_cnt[d];
        int base_x = xfer_cnt[d];
        int t0, dc;
        bit finished;
        logic [15:0] elem [16];
        exp_t e;
        ready_mode = mode;
        for (int p = 0; p < n; p++) begin
            case (fill)
                0:       elem[p] = 16'(p);
                1:       elem[p] = (p < 4) ? 16'(p + 1) : 16'(-(p - 3));
                default: elem[p] = 16'($urandom);
            endcase
        end
        bus[d] = '0;
        for (int p = 0; p < n; p++) bus[d][p*16 +: 16] = elem[p];
        for (int s = 0; s < n; s++) begin
            e.data = elem[src_pos(d, s)];
            e.idx  = s;
            e.last = (s == n - 1);
            exp_q[d].push_back(e);
        end
        @(posedge clk); #1;
        start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 8; i++) bus[d][i*32 +: 32] = $urandom;
        finished = 1'b0;
        for (int i = 0; i < 400 && !finished; i++) begin
            @(posedge clk); #1;
            if (mid && i == 3) begin
                for (int j = 0; j < 8; j++) bus[d][j*32 +: 32] = $urandom;
                start[d] = 1'b1;
            end
            if (mid && i == 4) start[d] = 1'b0;
            if (rst_at > 0 && xfer_cnt[d] - base_x >= rst_at) begin
                #2;
                reset = 1'b1;
                #1;
                chk("rst_valid", d, o_valid[d], 0);
                chk("rst_data", d, o_data[d], 0);
                chk("rst_index", d, get_idx(d), 0);
                chk("rst_last_busy_done", d, {o_last[d], o_busy[d], o_done[d]}, 0);
                exp_q[d].delete();
                for (int j = 0; j < ND; j++) begin
                    held_v[j] = 1'b0;
                    prev_done[j] = 1'b0;
                end
                dc = done_cnt[d];
                repeat (2) @(posedge clk);
                #1 reset = 1'b0;
                repeat (n + 4) @(posedge clk);
                #1;
                chk("no_done_after_reset", d, done_cnt[d] - dc, 0);
                chk("idle_after_reset", d, {o_busy[d], o_valid[d]}, 0);
                return;
            end
            if (done_cnt[d] > base_done) finished = 1'b1;
        end
        if (!finished) chk("done_timeout", d, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", d, exp_q[d].size(), 0);
        chk("xfer_count", d, xfer_cnt[d] - base_x, n);
        chk("done_count", d, done_cnt[d] - base_done, 1);
        if (mode == 0) chk("done_latency", d, done_cyc[d] - t0, n);
    endtask

    initial begin
        start = '0;
        for (int d = 0; d < ND; d++) begin
            bus[d] = '0;
            xfer_cnt[d] = 0;
            done_cnt[d] = 0;
            done_cyc[d] = 0;
            held_v[d] = 1'b0;
            prev_done[d] = 1'b0;
            held_val[d] = 0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            chk("reset_data_index", d, pack_out(d), 0);
            chk("reset_flags", d, {o_valid[d], o_busy[d], o_done[d]}, 0);
        end
        reset = 1'b0;

        run_stream(0, 0, 0, 1'b0, 0);   // sequential map, full throughput
        run_stream(0, 0, 1, 1'b0, 0);   // ready pattern 1,0,0,1
        run_stream(1, 1, 0, 1'b0, 0);   // HWC, signed channels
        run_stream(2, 1, 0, 1'b0, 0);   // CHW, signed channels
        run_stream(1, 1, 2, 1'b0, 0);
        run_stream(0, 2, 0, 1'b1, 0);   // start re-pulsed mid-stream
        run_stream(0, 2, 0, 1'b0, 5);   // reset after five transfers
        run_stream(0, 2, 2, 1'b0, 0);
        run_stream(3, 2, 0, 1'b0, 0);   // single element map
        run_stream(3, 2, 1, 1'b0, 0);
        for (int d = 0; d < ND; d++) run_stream(d, 2, 2, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/flatten_stream.md
# flatten_stream

Parametrised successor to the single-channel flatten stage: captures a CHANNELS×ROWS×COLS feature map presented as one flat bus and streams it out one signed element per transfer over a valid/ready interface. Supports channel-major (CHW) or interleaved (HWC) ordering and downstream backpressure. Provides last/index sideband for the dense layer. Sits between the final pooling stage and the fully-connected layer.

## Interface
- DATA_W, 16, element width in bits (signed two's complement)
- ROWS, 4, feature-map rows
- COLS, 4, feature-map columns
- CHANNELS, 1, feature-map channels
- ORDER, 0, 0 = CHW (col fastest, then row, then channel); 1 = HWC (channel fastest, then col, then row)
- N (localparam) = CHANNELS*ROWS*COLS; IDX_W (localparam) = max(1, $clog2(N))

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request capture of feature_map_flat
- feature_map_flat  in  N*DATA_W  element (c,r,k) at bits [((c*ROWS+r)*COLS+k)*DATA_W +: DATA_W]
- out_data  out  DATA_W signed  current element
- out_valid  out  1  out_data/out_last/out_index valid
- out_ready  in  1  downstream accepts when high with out_valid
- out_last  out  1  high with final element of the map
- out_index  out  IDX_W  sequence number of current element, 0..N-1
- busy  out  1  high from capture until done pulse (inclusive)
- done  out  1  one-cycle pulse after final transfer

## Operation
- States: IDLE, STREAM, DONE.
- IDLE: busy=0, out_valid=0. start=1 registers the full bus into an internal buffer, clears sequence counter, moves to STREAM.
- STREAM: out_valid=1; out_data = buffered element selected by counter and ORDER; out_index = counter; out_last = (counter == N-1).
- Transfer = out_valid && out_ready. On transfer: counter increments; on transfer with out_last, go to DONE.
- No transfer: out_data, out_index, out_last held stable.
- DONE: out_valid=0, done=1 for exactly one cycle, busy=1; next state IDLE.
- start outside IDLE ignored; buffer not overwritten; changes to feature_map_flat after capture have no effect.
- Element mapping: CHW sequence s → c=s/(ROWS*COLS), r=(s/COLS)%ROWS, k=s%COLS. HWC sequence s → c=s%CHANNELS, k=(s/CHANNELS)%COLS, r=s/(CHANNELS*COLS). Order decomposition is implemented with nested counters (no dividers).
- No arithmetic on data; sign preserved bit-exact.

## Timing
- Reset: all outputs 0; state IDLE; counter 0; buffer contents don't-care.
- start high in cycle T (IDLE) → out_valid high from T+1 with out_index 0.
- With out_ready held high: element s is presented in cycle T+1+s; out_last in T+N; done in T+N+1; IDLE in T+N+2 (earliest next start accepted at T+N+2).
- Full throughput: one element per cycle; no bubbles between elements.
- out_valid never drops in STREAM before the last transfer, regardless of out_ready.
- N=1: out_last is high on element 0.
- Reset mid-stream: outputs 0 immediately (asynchronous); the stream is abandoned; no done pulse.

## Structure
- Shared package cnn_pkg holds order encodings (ORDER_CHW=0, ORDER_HWC=1) and the state enum for flatten-type blocks.
- One sub-module: flatten_index_gen (nested channel/row/col counters producing buffer offset, index and last for the selected ORDER); the top level holds the FSM, buffer and output mux.

## Test plan
- Default parameters; map values 0x0000..0x000F (element k,r at r*4+k); start one cycle; out_ready=1 → out_data 0..15 on 16 consecutive cycles, out_last on 0x000F, done one cycle later, busy low after.
- Backpressure: same map, out_ready toggled 1,0,0,1 repeating → each element held stable while stalled, no loss or duplication, 16 transfers total.
- CHANNELS=2, ROWS=COLS=2, ORDER=1, channel0={1,2,3,4}, channel1={-1,-2,-3,-4} → stream 1,-1,2,-2,3,-3,4,-4 with sign preserved; ORDER=0 → 1,2,3,4,-1,-2,-3,-4.
- start reasserted mid-stream with a different bus → ignored; output continues from the original buffer.
- Reset asserted after element 5 → all outputs 0 that cycle, no done pulse; a new start after release streams from index 0.
- N=1 configuration: single element with out_last=1, done the following cycle.
